// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor.
//   Processes DIGIT bits per clock, so one operation takes N = WIDTH/DIGIT
//   RUN steps plus the accept cycle (N+1 cycles from start to done).
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   begin an operation (accepted only in IDLE)
//   a, b    in   WIDTH-bit operands
//   sub     in   0 = a+b, 1 = a-b
//   busy    out  high while an operation is in progress
//   done    out  one-cycle completion pulse
//   result  out  registered sum/difference, held until the next completion
//   cout    out  carry out of the MSB (for sub, 1 = no borrow)
//   ovf     out  two's-complement signed overflow
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last completed result
// RUN    | one digit step per clock, N steps in total
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  generate
    if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  localparam int N  = WIDTH / DIGIT;
  // N+1 keeps the counter at least one bit wide when DIGIT == WIDTH.
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dsum;
  logic             cin_msb;
  logic             last_step;

  always_comb begin
    a_dig     = a_q[DIGIT-1:0];
    // Subtraction is a + ~b + 1; the +1 comes from the carry preset at accept.
    b_dig     = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};
    dsum      = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of this digit, recovered from its sum bit.
    cin_msb   = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    last_step = (cnt_q == CW'(N - 1));

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          part_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the MSB end; after N steps the LSB digit is at the bottom.
        part_d  = (part_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          result_d = part_d;
          cout_d   = dsum[DIGIT];
          ovf_d    = cin_msb ^ dsum[DIGIT];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range 2..64.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per clock; SHALL be >=1 and divide WIDTH exactly, otherwise elaboration SHALL fail.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 SHALL have port a, input, WIDTH bits: first operand.
REQ-007 SHALL have port b, input, WIDTH bits: second operand.
REQ-008 SHALL have port sub, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port result, output, WIDTH bits: registered sum/difference.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the MSB (for sub, 1 = no borrow).
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 SHALL define N = WIDTH/DIGIT as the number of digit steps per operation.
REQ-015 SHALL implement states IDLE and RUN; IDLE is the state after reset.
REQ-016 In IDLE, start=1 at a rising edge SHALL latch a, b and sub, set the carry register to sub, clear the step counter, and enter RUN; busy SHALL be high from the next cycle.
REQ-017 In RUN, each rising edge SHALL add the low DIGIT bits of the a shift register, the low DIGIT bits of the b shift register (inverted when sub=1) and the carry register.
REQ-018 Each RUN edge SHALL shift the DIGIT sum bits into the partial-result register from the MSB end, shift a and b right by DIGIT, and update carry.
REQ-019 On the N-th RUN edge, result SHALL load the completed value, cout the final carry and ovf (carry into MSB XOR carry out of MSB); the same edge SHALL set done=1, busy=0 and return to IDLE.
REQ-020 Latency SHALL be exactly N+1 cycles: done is high N+1 cycles after the cycle in which start was accepted.
REQ-021 done SHALL be high for exactly one cycle per completed operation.
REQ-022 start SHALL be ignored while in RUN; operand or sub changes during RUN SHALL not affect the operation in flight.
REQ-023 start=1 in the cycle done is high (state IDLE) SHALL be accepted; the new operation is back-to-back with no idle cycle.
REQ-024 result, cout and ovf SHALL hold their values until the next completion; they SHALL not change at start or during RUN.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; results SHALL be identical for every legal DIGIT given the same WIDTH and operands.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, cout=0, ovf=0, and clear carry, counter and shift registers.
REQ-027 rst SHALL take priority over start and over any RUN step in the same cycle; a reset during RUN SHALL abort the operation with no done pulse.

Verification
REQ-028 Add, WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, sub=0, start pulsed -> busy for 8 cycles, done on the 9th cycle, result=0x96, cout=0, ovf=1.
REQ-029 Add wrap: a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0; and a=0x80, b=0x80 -> result=0x00, cout=1, ovf=1.
REQ-030 Subtract: a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, ovf=0; and a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
REQ-031 WIDTH=16, DIGIT=4: a=0x1234, b=0xEDCC, sub=0 -> done 5 cycles after start, result=0x0000, cout=1; a second start held high in the done cycle yields a second done exactly 5 cycles later.
REQ-032 Robustness: start re-asserted and a/b changed mid-RUN -> first result unaffected, a single done pulse; rst asserted on step 4 of 8 -> no done pulse, all outputs 0, next start completes normally.
